logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit: WIDTH-bit operands, 8 operations, valid/ready handshake on input and output, registered result with zero/parity flags.
- Optional accumulate mode chains operations through an internal accumulator: the previous result replaces operand A.
- Sits between an operand source (register file or command decoder) and a result sink that may stall.

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_core.sv | 28 ++
 rtl/logic_unit_pipe.sv | 100 ++++++++++
 tb/tb_logic_unit_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int unsigned OPCODE_W = 3;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_NOT   = 3'b000;
  localparam opcode_t OP_OR    = 3'b001;
  localparam opcode_t OP_AND   = 3'b010;
  localparam opcode_t OP_XOR   = 3'b011;
  localparam opcode_t OP_NAND  = 3'b100;
  localparam opcode_t OP_NOR   = 3'b101;
  localparam opcode_t OP_XNOR  = 3'b110;
  localparam opcode_t OP_PASSB = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise operation selected by opcode; no carries, result is WIDTH bits.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_c
);

  // Every opcode value is decoded, so the case needs no default arm.
  always_comb begin
    y_c = '0;
    case (opcode)
      OP_NOT:   y_c = ~a;
      OP_OR:    y_c = a | b;
      OP_AND:   y_c = a & b;
      OP_XOR:   y_c = a ^ b;
      OP_NAND:  y_c = ~(a & b);
      OP_NOR:   y_c = ~(a | b);
      OP_XNOR:  y_c = ~(a ^ b);
      OP_PASSB: y_c = b;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes, result flags and an
// optional accumulator that can stand in for operand A.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          opcode,
  input  logic             acc_sel,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             zero_out,
  output logic             par_out
);

  logic             s1_valid;
  opcode_t          s1_op;
  logic             s1_acc_sel;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] acc;

  logic             in_hs_c;
  logic             s2_adv_c;
  logic [WIDTH-1:0] op_a_c;
  logic [WIDTH-1:0] result_c;

  // S1 moves on whenever S2 is empty or being drained this cycle.
  assign s2_adv_c = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_adv_c;
  assign in_hs_c  = in_valid & in_ready;
  assign op_a_c   = s1_acc_sel ? acc : s1_a;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .opcode (s1_op),
    .a      (op_a_c),
    .b      (s1_b),
    .y_c    (result_c)
  );

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_NOT;
      s1_acc_sel <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
    end else if (in_hs_c) begin
      s1_valid   <= 1'b1;
      s1_op      <= opcode;
      s1_acc_sel <= acc_sel;
      s1_a       <= a_in;
      s1_b       <= b_in;
    end else if (s2_adv_c) begin
      s1_valid   <= 1'b0;
    end
  end

  // Accumulator: a clear arriving with a new bundle beats the result of an
  // older bundle leaving S1 on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= ACC_INIT;
    end else if (in_hs_c && acc_clr) begin
      acc <= ACC_INIT;
    end else if (s2_adv_c) begin
      acc <= result_c;
    end
  end

  // Stage 2: registered result and flags, held while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_out     <= '0;
      zero_out  <= 1'b1;
      par_out   <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid <= 1'b1;
      y_out     <= result_c;
      zero_out  <= (result_c == '0);
      par_out   <= ^result_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed sequences plus randomized traffic.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] ACC0 = '0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, acc_sel, acc_clr, out_valid, out_ready;
  opcode_t      opcode;
  logic [W-1:0] a_in, b_in, y_out;
  logic         zero_out, par_out;

  logic         in_valid2, in_ready2, acc_sel2, acc_clr2, out_valid2, out_ready2;
  opcode_t      opcode2;
  logic [1:0]   a2, b2, y2;
  logic         zero2, par2;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(W), .ACC_INIT(ACC0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .acc_sel(acc_sel), .acc_clr(acc_clr), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
    .zero_out(zero_out), .par_out(par_out)
  );

  logic_unit_pipe #(.WIDTH(2), .ACC_INIT(2'b00)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .opcode(opcode2), .acc_sel(acc_sel2), .acc_clr(acc_clr2), .a_in(a2), .b_in(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .y_out(y2),
    .zero_out(zero2), .par_out(par2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random

  typedef struct {
    logic [W-1:0] y;
    logic         z;
    logic         p;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_acc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0:       return ~a;
      1:       return a | b;
      2:       return a & b;
      3:       return a ^ b;
      4:       return ~(a & b);
      5:       return ~(a | b);
      6:       return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  // Sink side: out_ready pattern changes just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: an output handshake seen at the falling edge completes on the next rise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y=0x%0h with nothing expected", y_out);
        end else begin
          e = sb.pop_front();
          check("y_out", 32'(y_out), 32'(e.y));
          check("zero_out", 32'(zero_out), 32'(e.z));
          check("par_out", 32'(par_out), 32'(e.p));
          if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0;
    opcode   = opcode_t'($urandom_range(0, 7));
    acc_sel  = 1'($urandom_range(0, 1));
    acc_clr  = 1'($urandom_range(0, 1));
    a_in     = W'($urandom);
    b_in     = W'($urandom);
  endtask

  // Present one bundle until accepted; the model is updated in bundle order.
  task automatic send(input int op, input bit sel, input bit clr,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    bit           done;
    exp_t         e;
    logic [W-1:0] opa;
    done     = 1'b0;
    in_valid = 1'b1;
    opcode   = opcode_t'(op);
    acc_sel  = sel;
    acc_clr  = clr;
    a_in     = a;
    b_in     = b;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (clr) m_acc = ACC0;
        opa   = sel ? m_acc : a;
        e.y   = ref_op(op, opa, b);
        e.z   = (e.y == '0);
        e.p   = ^e.y;
        e.cyc = cyc;
        e.lat = (rdy_mode == 0);
        m_acc = e.y;
        sb.push_back(e);
        done  = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: bundle op=%0d never accepted", op);
    end
    idle_inputs();
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 500 && (sb.size() != 0 || out_valid); t++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    m_acc      = ACC0;
    in_valid2  = 1'b0;
    opcode2    = OP_NOT;
    acc_sel2   = 1'b0;
    acc_clr2   = 1'b0;
    a2         = 2'b00;
    b2         = 2'b00;
    out_ready2 = 1'b1;
    idle_inputs();

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y_out", 32'(y_out), 32'd0);
    check("rst_zero_out", 32'(zero_out), 32'd1);
    check("rst_par_out", 32'(par_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All eight opcodes back-to-back on fixed operands.
    for (int op = 0; op < 8; op++) send(op, 1'b0, 1'b0, 8'hA5, 8'h0F);
    drain("drain_opcodes");

    // Accumulator chain: clear + OR 1, OR 2, XOR 3 gives 01, 03, 00.
    send(1, 1'b1, 1'b1, W'($urandom), 8'h01);
    send(1, 1'b1, 1'b0, W'($urandom), 8'h02);
    send(3, 1'b1, 1'b0, W'($urandom), 8'h03);
    drain("drain_accum");

    // Backpressure: two bundles fill the pipe, the third must wait.
    rdy_mode = 1;
    send(2, 1'b0, 1'b0, 8'h3C, 8'hF0);
    send(4, 1'b0, 1'b0, 8'h12, 8'h34);
    in_valid = 1'b1;
    opcode   = OP_XOR;
    acc_sel  = 1'b0;
    acc_clr  = 1'b0;
    a_in     = 8'h81;
    b_in     = 8'h18;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_y_out", 32'(y_out), 32'(sb[0].y));
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    send(3, 1'b0, 1'b0, 8'h81, 8'h18);
    send(7, 1'b0, 1'b0, 8'h00, 8'h5A);
    drain("drain_backpressure");

    // Minimum-width instance.
    in_valid2 = 1'b1;
    opcode2   = OP_AND;
    a2        = 2'b11;
    b2        = 2'b01;
    @(negedge clk);
    check("w2_in_ready", 32'(in_ready2), 32'd1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (out_valid2) begin
          seen = 1'b1;
          check("w2_y_out", 32'(y2), 32'd1);
          check("w2_par_out", 32'(par2), 32'd1);
          check("w2_zero_out", 32'(zero2), 32'd0);
        end
      end
      check("w2_out_seen", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1;

    // Reset while stalled with two bundles in flight.
    rdy_mode = 1;
    send(1, 1'b0, 1'b0, 8'h11, 8'h22);
    send(6, 1'b0, 1'b0, 8'h33, 8'h44);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_y_out", 32'(y_out), 32'd0);
    check("midrst_zero_out", 32'(zero_out), 32'd1);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    m_acc = ACC0;
    @(negedge clk);
    rst_n    = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send(0, 1'b1, 1'b0, W'($urandom), W'($urandom));
    drain("drain_after_reset");

    // Randomized traffic with stalls, gaps and accumulator chaining.
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        idle_inputs();
        @(posedge clk);
        #1;
      end
      send($urandom_range(0, 7), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           W'($urandom), W'($urandom));
    end
    drain("drain_random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
